// File: rtl/sprite_row_reader_if.sv
// Signal bundle between the sprite row reader, the sprite block memory and the
// VGA pixel timing logic. The reader is the master: it drives the memory address
// and the pixel stream.
interface sprite_row_reader_if #(
    parameter int WORD_SIZE  = 32,
    parameter int ADDR_BITS  = 4,
    parameter int PIXEL_BITS = 2
);
    logic                  start;
    logic [ADDR_BITS-1:0]  row;
    logic                  flip;
    logic [ADDR_BITS-1:0]  mem_addr;
    logic [WORD_SIZE-1:0]  mem_data;
    logic                  pix_en;
    logic [PIXEL_BITS-1:0] pix;
    logic                  pix_valid;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, row, flip, mem_data, pix_en,
        output mem_addr, pix, pix_valid, busy, done
    );

    modport slave (
        output start, row, flip, mem_data, pix_en,
        input  mem_addr, pix, pix_valid, busy, done
    );
endinterface

// File: rtl/sprite_row_reader.sv
// Fetches one sprite row word from the sprite block memory and serializes it into
// palette-index pixels, one per pixel strobe, optionally mirrored.
module sprite_row_reader #(
    parameter int WORD_SIZE  = 32,
    parameter int ADDR_BITS  = 4,
    parameter int PIXEL_BITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    sprite_row_reader_if.master   bus,
    output logic [1:0]            dbg_state_o
);
    localparam int PIX_PER_WORD = WORD_SIZE / PIXEL_BITS;
    localparam int CNT_W        = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIX_PER_WORD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        LOAD  = 2'd2,
        SHIFT = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [WORD_SIZE-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  flip_q, flip_d;
    logic [PIXEL_BITS-1:0] pix_q, pix_d;
    logic                  pix_valid_q, pix_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            shreg_q     <= '0;
            cnt_q       <= '0;
            flip_q      <= 1'b0;
            pix_q       <= '0;
            pix_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            flip_q      <= flip_d;
            pix_q       <= pix_d;
            pix_valid_q <= pix_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Outputs are computed from the next state so that every output is a flop.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        flip_d      = flip_q;
        done_d      = 1'b0;
        pix_valid_d = 1'b0;
        pix_d       = '0;
        busy_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    addr_d  = bus.row;
                    flip_d  = bus.flip;
                    state_d = REQ;
                end
            end
            REQ: begin
                state_d = LOAD;
            end
            LOAD: begin
                shreg_d = bus.mem_data;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (bus.pix_en) begin
                    if (cnt_q == LAST_PIX) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        shreg_d = flip_q ? (shreg_q << PIXEL_BITS) : (shreg_q >> PIXEL_BITS);
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d      = (state_d != IDLE);
        pix_valid_d = (state_d == SHIFT);
        if (pix_valid_d) begin
            pix_d = flip_d ? shreg_d[WORD_SIZE-1 -: PIXEL_BITS] : shreg_d[PIXEL_BITS-1:0];
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.pix       = pix_q;
    assign bus.pix_valid = pix_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_sprite_row_reader.sv
// Bench for sprite_row_reader: a registered memory model feeds the reader, a driver
// issues row fetches and strobes, and a monitor compares each pixel to the queue.
module tb_sprite_row_reader;
  logic clk;
  logic reset;
  logic [1:0] dbg_state;

  sprite_row_reader_if #(.WORD_SIZE(32), .ADDR_BITS(4), .PIXEL_BITS(2)) bus ();

  sprite_row_reader #(.WORD_SIZE(32), .ADDR_BITS(4), .PIXEL_BITS(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- sprite memory model (1-cycle registered read) ----------------
  logic [31:0] mem [16];
  always @(posedge clk) bus.mem_data <= mem[bus.mem_addr];

  // ---------------- scoreboard state ----------------
  logic [1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int exp_done = 0;
  logic [3:0] cur_row;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pattern(input logic [1:0] p0, input logic [1:0] p1,
                              input logic [1:0] p2, input logic [1:0] p3, input int reps);
    for (int r = 0; r < reps; r++) begin
      exp_q.push_back(p0);
      exp_q.push_back(p1);
      exp_q.push_back(p2);
      exp_q.push_back(p3);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.pix_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL pix_unexpected: got pix=%0d with empty queue at %0t", bus.pix, $time);
        end else begin
          if (bus.pix !== exp_q[0]) begin
            failures++;
            $display("FAIL pix_value: got %0d expected %0d at %0t", bus.pix, exp_q[0], $time);
          end
          if (bus.pix_en) void'(exp_q.pop_front());
        end
      end else begin
        checks++;
        if (bus.pix !== 2'd0) begin
          failures++;
          $display("FAIL pix_idle_zero: got %0d expected 0 at %0t", bus.pix, $time);
        end
      end
      if (bus.done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  // Issues start for one cycle and checks the fetch latency to the first pixel.
  task automatic start_row(input logic [3:0] row, input logic flp);
    bus.start = 1'b1;
    bus.row   = row;
    bus.flip  = flp;
    cur_row   = row;
    tick();
    bus.start = 1'b0;
    check("addr_after_e0", 32'(bus.mem_addr), 32'(row));
    check("busy_after_e0", 32'(bus.busy), 32'd1);
    check("done_after_e0", 32'(bus.done), 32'd0);
    check("valid_after_e0", 32'(bus.pix_valid), 32'd0);
    tick();
    check("valid_after_e1", 32'(bus.pix_valid), 32'd0);
    tick();
    check("valid_after_e2", 32'(bus.pix_valid), 32'd1);
  endtask

  // Strobes every gap cycles until done; optional ignored start and mid-row reset.
  task automatic run_pixels(input int gap, input int ign_at, input int rst_after, input bit chain);
    int strobes = 0;
    bit found = 0;
    bit ign = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (rst_after >= 0 && strobes == rst_after) begin
        bus.pix_en = 1'b0;
        reset = 1'b1;
        tick();
        check("rst_pix", 32'(bus.pix), 32'd0);
        check("rst_valid", 32'(bus.pix_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        reset = 1'b0;
        exp_q.delete();
        repeat (3) begin
          tick();
          check("rst_no_done", 32'(bus.done), 32'd0);
        end
        return;
      end
      bus.pix_en = ((cyc % gap) == 0);
      ign = (cyc == ign_at);
      if (ign) begin
        bus.start = 1'b1;
        bus.row   = 4'd5;
        bus.flip  = 1'b1;
      end
      if (bus.pix_en && bus.pix_valid) strobes++;
      tick();
      if (ign) begin
        bus.start = 1'b0;
        check("ignored_start_addr", 32'(bus.mem_addr), 32'(cur_row));
        check("ignored_start_busy", 32'(bus.busy), 32'd1);
      end
      if (bus.done) begin
        found = 1;
        break;
      end
    end
    bus.pix_en = 1'b0;
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done expected done within 300 cycles");
      return;
    end
    exp_done++;
    check("strobe_count", 32'(strobes), 32'd16);
    check("end_busy", 32'(bus.busy), 32'd0);
    check("end_valid", 32'(bus.pix_valid), 32'd0);
    check("end_pix", 32'(bus.pix), 32'd0);
    check("end_queue_empty", 32'(exp_q.size()), 32'd0);
    if (!chain) begin
      tick();
      check("done_one_cycle", 32'(bus.done), 32'd0);
      check("done_count", 32'(done_cnt), 32'(exp_done));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[3] = 32'hE4E4E4E4;
    mem[0] = 32'h0000001B;
    mem[5] = 32'hFFFF0000;
    bus.start  = 1'b0;
    bus.row    = 4'd0;
    bus.flip   = 1'b0;
    bus.pix_en = 1'b0;
    cur_row    = 4'd0;
    reset      = 1'b1;
    tick();
    tick();
    check("reset_pix", 32'(bus.pix), 32'd0);
    check("reset_valid", 32'(bus.pix_valid), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_addr", 32'(bus.mem_addr), 32'd0);
    reset = 1'b0;
    tick();

    // Basic fetch, LSB-first: E4 -> 0,1,2,3
    push_pattern(2'd0, 2'd1, 2'd2, 2'd3, 4);
    start_row(4'd3, 1'b0);
    run_pixels(1, -1, -1, 1'b0);

    // Mirrored: 3,2,1,0
    push_pattern(2'd3, 2'd2, 2'd1, 2'd0, 4);
    start_row(4'd3, 1'b1);
    run_pixels(1, -1, -1, 1'b0);

    // Strobe every third cycle: 1B -> 3,2,1,0 then zeros
    push_pattern(2'd3, 2'd2, 2'd1, 2'd0, 1);
    push_pattern(2'd0, 2'd0, 2'd0, 2'd0, 3);
    start_row(4'd0, 1'b0);
    run_pixels(3, -1, -1, 1'b0);

    // Start while shifting is ignored; start in the done cycle is accepted
    push_pattern(2'd0, 2'd1, 2'd2, 2'd3, 4);
    start_row(4'd3, 1'b0);
    run_pixels(1, 4, -1, 1'b1);
    push_pattern(2'd0, 2'd0, 2'd0, 2'd0, 2);
    push_pattern(2'd3, 2'd3, 2'd3, 2'd3, 2);
    start_row(4'd5, 1'b0);
    run_pixels(1, -1, -1, 1'b0);

    // Mid-row reset after 7 pixels, then a normal fetch
    push_pattern(2'd0, 2'd1, 2'd2, 2'd3, 4);
    start_row(4'd3, 1'b0);
    run_pixels(1, -1, 7, 1'b0);
    check("no_done_after_reset", 32'(done_cnt), 32'(exp_done));
    push_pattern(2'd3, 2'd2, 2'd1, 2'd0, 1);
    push_pattern(2'd0, 2'd0, 2'd0, 2'd0, 3);
    start_row(4'd0, 1'b0);
    run_pixels(1, -1, -1, 1'b0);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end
endmodule
